// File: rtl/twdl_pkg.sv
`default_nettype none
// ============================================================================
// Package : twdl_pkg
// Brief   : Stage table, FSM states and shared constants for the twiddle
//           sequencer of the 1200-point mixed-radix FFT.
// Rev     : 1.0
// ============================================================================
package twdl_pkg;

    localparam int FFT_LEN   = 1200;
    localparam int LAT       = 24;
    localparam int TBL_DEPTH = 5;

    typedef struct packed {
        logic [11:0] den;
        logic [11:0] period;
        logic [19:0] quot;
        logic [11:0] rem;
    } stage_cfg_t;

    // Radix order 4, 4, 5, 5, 3; quot/rem are floor(2^20/den) and 2^20 mod den.
    localparam stage_cfg_t STAGE_TBL [TBL_DEPTH] = '{
        '{den: 12'd1200, period: 12'd300, quot: 20'd873,    rem: 12'd976},
        '{den: 12'd300,  period: 12'd75,  quot: 20'd3495,   rem: 12'd76},
        '{den: 12'd75,   period: 12'd15,  quot: 20'd13981,  rem: 12'd1},
        '{den: 12'd15,   period: 12'd3,   quot: 20'd69905,  rem: 12'd1},
        '{den: 12'd3,    period: 12'd1,   quot: 20'd349525, rem: 12'd1}
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/twdl_dly_line.sv
`default_nettype none
// ============================================================================
// Module : twdl_dly_line
// Brief  : DEPTH-deep register delay of a WIDTH-bit word, synchronous clear.
// Rev    : 1.0
// ============================================================================
module twdl_dly_line #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/twdl_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : twdl_seq_ctrl
// Brief  : Steps the twiddle generator through all FFT stages and emits a
//          latency-matched valid/sop/stage strobe for its coefficient output.
// Rev    : 1.0
// ============================================================================
module twdl_seq_ctrl
    import twdl_pkg::*;
#(
    parameter int FFT_LEN  = twdl_pkg::FFT_LEN,
    parameter int N_STAGES = 5,
    parameter int GAP      = 4,
    parameter int LAT      = twdl_pkg::LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        twdl_sop,
    output logic [11:0] numerator,
    output logic [11:0] demoninator,
    output logic [19:0] twdl_quotient,
    output logic [11:0] twdl_remainder,
    output logic        cfg_valid,
    output logic        coef_valid,
    output logic        coef_sop,
    output logic [2:0]  coef_stage
);

    localparam int          GW          = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [10:0] LAST_SAMPLE = 11'(FFT_LEN - 1);
    localparam logic [10:0] DRAIN_LAST  = 11'(LAT - 1);
    localparam logic [2:0]  LAST_STAGE  = 3'(N_STAGES - 1);

    state_t        state_q;
    logic [2:0]    stage_q;
    logic [2:0]    stage_d;
    logic [10:0]   sample_q;
    logic [GW-1:0] gap_q;
    logic          busy_q;
    logic          done_q;
    logic          twdl_sop_q;
    logic          cfg_valid_q;
    stage_cfg_t    cfg_q;
    logic [4:0]    dly_out;

    assign stage_d = stage_q + 3'd1;

    // The sample counter doubles as the drain timer once the last stage ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            sample_q    <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            twdl_sop_q  <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            twdl_sop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !done_q) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        stage_q     <= '0;
                        sample_q    <= '0;
                        twdl_sop_q  <= 1'b1;
                        cfg_valid_q <= 1'b1;
                        cfg_q       <= STAGE_TBL[0];
                    end
                end
                ST_RUN: begin
                    if (sample_q == LAST_SAMPLE) begin
                        if (stage_q == LAST_STAGE) begin
                            state_q     <= ST_DRAIN;
                            sample_q    <= '0;
                            cfg_valid_q <= 1'b0;
                        end else if (GAP == 0) begin
                            stage_q    <= stage_d;
                            sample_q   <= '0;
                            twdl_sop_q <= 1'b1;
                            cfg_q      <= STAGE_TBL[stage_d];
                        end else begin
                            state_q     <= ST_GAP;
                            gap_q       <= '0;
                            cfg_valid_q <= 1'b0;
                        end
                    end else begin
                        sample_q <= sample_q + 11'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q     <= ST_RUN;
                        stage_q     <= stage_d;
                        sample_q    <= '0;
                        twdl_sop_q  <= 1'b1;
                        cfg_valid_q <= 1'b1;
                        cfg_q       <= STAGE_TBL[stage_d];
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (sample_q == DRAIN_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        sample_q <= sample_q + 11'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    twdl_dly_line #(
        .WIDTH (5),
        .DEPTH (LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({cfg_valid_q, twdl_sop_q, stage_q}),
        .q_o (dly_out)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign twdl_sop       = twdl_sop_q;
    assign cfg_valid      = cfg_valid_q;
    assign numerator      = cfg_q.period;
    assign demoninator    = cfg_q.den;
    assign twdl_quotient  = cfg_q.quot;
    assign twdl_remainder = cfg_q.rem;
    assign coef_valid     = dly_out[4];
    assign coef_sop       = dly_out[3];
    assign coef_stage     = dly_out[2:0];

endmodule
`default_nettype wire
